// File: rtl/cellram_ctrl.sv
// -----------------------------------------------------------------------------
// cellram_ctrl
//   Burst controller placed directly upstream of a CellRAM device. After reset
//   it writes the bus configuration register once (cre high, BCR value on
//   addr), then serves one host read or write burst at a time.
//
//   Optional feature macro: CELLRAM_CTRL_TIMEOUT_EN
//     When defined, CFG_WAIT and WAIT give up after TIMEOUT cycles without
//     mem_wait=1, pulse err and recover. When undefined they wait forever and
//     err is tied to 0.
//
// Ports
//   clk        in   system clock, all device outputs launched on rising edge
//   reset      in   asynchronous active-low reset
//   req        in   start burst, sampled only while busy=0
//   req_we     in   1=write burst, 0=read burst (sampled with req)
//   req_addr   in   [22:0] start word address (sampled with req)
//   req_len    in   [7:0] burst length in words, 0 means 256
//   wr_data    in   [15:0] write word, consumed on cycles with wr_ready=1
//   wr_ready   out  wr_data consumed this cycle
//   rd_data    out  [15:0] read word, valid with rd_valid
//   rd_valid   out  one pulse per read word
//   busy       out  high while configuring and from req accept until done
//   done       out  one-cycle pulse at burst end
//   err        out  one-cycle timeout pulse
//   ce/we/oe/adv/lb/ub  out  CellRAM controls, active low
//   cre        out  CellRAM configuration register enable, active high
//   addr       out  [22:0] device address / BCR value
//   data       io   [15:0] device data, driven only during write beats
//   mem_wait   in   device wait, Z/X behaves as 0
// -----------------------------------------------------------------------------
module cellram_ctrl #(
    parameter logic [22:0] BCR_VALUE = 23'h009D1F,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [22:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ce,
    output logic        we,
    output logic        oe,
    output logic        cre,
    output logic        adv,
    output logic        lb,
    output logic        ub,
    output logic [22:0] addr,
    inout  wire  [15:0] data,
    input  logic        mem_wait
);

    typedef enum logic [2:0] {
        S_CFG,
        S_CFG_WAIT,
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_WR_BURST,
        S_RD_BURST,
        S_RECOVER
    } state_t;

    if (RD_LAT < 1 || RD_LAT > 256 || TIMEOUT < 1) begin : g_param_check
        $error("cellram_ctrl: RD_LAT must be 1..256 and TIMEOUT at least 1");
    end

    // Cycles spent in RD_BURST before the first sample; the transition out of
    // WAIT already accounts for one of the RD_LAT cycles.
    localparam logic [7:0] SKIP_INIT = 8'(RD_LAT - 1);

    state_t      r_state;
    logic        r_is_wr;
    logic [8:0]  r_cnt;
    logic [7:0]  r_skip;
    logic        r_ce;
    logic        r_we;
    logic        r_oe;
    logic        r_cre;
    logic        r_adv;
    logic [22:0] r_addr;
    logic        r_drive;
    logic        r_busy;
    logic        r_wr_ready;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_done;
    logic        r_err;

`ifdef CELLRAM_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] r_to;
`endif

    // Write data goes straight from the host port to the pins during beats so
    // the word presented with wr_ready is the one the device sees.
    assign data     = r_drive ? wr_data : 16'hzzzz;

    assign ce       = r_ce;
    assign we       = r_we;
    assign oe       = r_oe;
    assign cre      = r_cre;
    assign adv      = r_adv;
    assign lb       = r_ce;
    assign ub       = r_ce;
    assign addr     = r_addr;
    assign busy     = r_busy;
    assign wr_ready = r_wr_ready;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign done     = r_done;
    assign err      = r_err;

    // Outputs are registered alongside the state: every transition sets the
    // pin values the next state presents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_CFG;
            r_is_wr    <= 1'b0;
            r_cnt      <= '0;
            r_skip     <= '0;
            r_ce       <= 1'b1;
            r_we       <= 1'b1;
            r_oe       <= 1'b1;
            r_cre      <= 1'b0;
            r_adv      <= 1'b1;
            r_addr     <= '0;
            r_drive    <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef CELLRAM_CTRL_TIMEOUT_EN
            r_to       <= '0;
`endif
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                S_CFG: begin
                    r_ce    <= 1'b0;
                    r_cre   <= 1'b1;
                    r_addr  <= BCR_VALUE;
                    r_state <= S_CFG_WAIT;
`ifdef CELLRAM_CTRL_TIMEOUT_EN
                    r_to    <= '0;
`endif
                end

                S_CFG_WAIT: begin
                    r_cre <= 1'b0;
                    // An undriven mem_wait fails this test and reads as 0.
                    if (mem_wait) begin
                        r_ce    <= 1'b1;
                        r_state <= S_RECOVER;
                    end
`ifdef CELLRAM_CTRL_TIMEOUT_EN
                    else if (r_to == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_ce    <= 1'b1;
                        r_state <= S_RECOVER;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
`endif
                end

                S_IDLE: begin
                    if (req) begin
                        r_busy  <= 1'b1;
                        r_is_wr <= req_we;
                        r_cnt   <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                        r_ce    <= 1'b0;
                        r_adv   <= 1'b0;
                        r_addr  <= req_addr;
                        r_we    <= ~req_we;
                        r_oe    <= 1'b1;
                        r_state <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    r_adv   <= 1'b1;
                    r_state <= S_WAIT;
`ifdef CELLRAM_CTRL_TIMEOUT_EN
                    r_to    <= '0;
`endif
                end

                S_WAIT: begin
                    if (mem_wait) begin
                        if (r_is_wr) begin
                            r_wr_ready <= 1'b1;
                            r_drive    <= 1'b1;
                            r_state    <= S_WR_BURST;
                        end else begin
                            r_oe    <= 1'b0;
                            r_skip  <= SKIP_INIT;
                            r_state <= S_RD_BURST;
                        end
                    end
`ifdef CELLRAM_CTRL_TIMEOUT_EN
                    else if (r_to == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_ce    <= 1'b1;
                        r_we    <= 1'b1;
                        r_oe    <= 1'b1;
                        r_state <= S_RECOVER;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
`endif
                end

                S_WR_BURST: begin
                    // Each cycle here is one consumed beat; r_cnt==1 marks the last.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 9'd1) begin
                        r_drive <= 1'b0;
                        r_ce    <= 1'b1;
                        r_we    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_RECOVER;
                    end else begin
                        r_wr_ready <= 1'b1;
                    end
                end

                S_RD_BURST: begin
                    if (r_skip != 8'd0) begin
                        r_skip <= r_skip - 1'b1;
                    end else begin
                        r_rd_data  <= data;
                        r_rd_valid <= 1'b1;
                        r_cnt      <= r_cnt - 1'b1;
                        if (r_cnt == 9'd1) begin
                            r_ce    <= 1'b1;
                            r_oe    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_RECOVER;
                        end
                    end
                end

                S_RECOVER: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cellram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cellram_ctrl
//   Self-checking bench for cellram_ctrl. A behavioural CellRAM responder and
//   a host write-stream driver live in the bench; expected read words come
//   from a word-addressed reference memory updated at burst level.
//   Optional feature macro: CELLRAM_CTRL_TIMEOUT_EN (adds the timeout case).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cellram_ctrl;

    localparam logic [22:0] BCR  = 23'h009D1F;
    localparam int          RDL  = 2;
    localparam int          TMO  = 16;
    localparam int          MASK = 'h7FFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [22:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready, rd_valid, busy, done, err;
    logic        ce, we, oe, cre, adv, lb, ub;
    logic [15:0] rd_data;
    logic [22:0] addr;
    wire  [15:0] data;
    logic        mem_wait = 1'b0;

    logic        dev_drive = 1'b0;
    logic [15:0] dev_q = '0;
    assign data = dev_drive ? dev_q : 16'hzzzz;

    cellram_ctrl #(.BCR_VALUE(BCR), .RD_LAT(RDL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err(err), .ce(ce), .we(we), .oe(oe),
        .cre(cre), .adv(adv), .lb(lb), .ub(ub), .addr(addr), .data(data),
        .mem_wait(mem_wait)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side observation state
    int  cyc = 0, n_wr = 0, n_rd = 0, n_done = 0, n_err = 0;
    int  wait_cyc = 0, first_rd_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;
    int  done_cyc = 0, adv_cyc = 0, err_cyc = 0, idle_cyc = 0;
    bit  first_rd_pend = 0, first_wr_pend = 0, lbub_bad = 0;
    logic ce_at_err = 1'b0;

    logic [15:0] ref_mem [int];
    logic [15:0] dev_mem [int];
    logic [15:0] rd_q [$];
    logic [15:0] wbuf [256];
    int  wr_idx = 0;

    // Device responder state
    int  dev_phase = 0, wcnt = 0, rk = 0, beat = 0, dev_addr = 0;
    bit  dev_wr = 0, dev_stall = 0;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [15:0] dev_rd(input int a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return init_word(a);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor plus CellRAM responder, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (lb !== ce || ub !== ce) lbub_bad = 1;
            if (err)  begin n_err++; err_cyc = cyc; ce_at_err = ce; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (!ce && !adv) adv_cyc = cyc;
            if (rd_valid) begin
                n_rd++;
                if (first_rd_pend) begin first_rd_cyc = cyc; first_rd_pend = 0; end
                if (rd_q.size() == 0) check("rd_extra", 1, 0);
                else                  check("rd_data", rd_data, rd_q.pop_front());
            end
            if (wr_ready) begin
                n_wr++;
                if (first_wr_pend) begin first_wr_cyc = cyc; first_wr_pend = 0; end
                last_wr_cyc = cyc;
                wr_idx++;
            end

            if (!reset || ce) begin
                mem_wait = 1'b0; dev_drive = 1'b0; dev_phase = 0;
            end else if (cre) begin
                dev_phase = 1; wcnt = $urandom_range(1, 4);
            end else if (!adv) begin
                dev_addr = int'(addr); dev_wr = !we; dev_phase = 1;
                wcnt = $urandom_range(1, 4); beat = 0;
            end else if (dev_phase == 1) begin
                if (wcnt == 0 && !dev_stall) begin
                    mem_wait = 1'b1; dev_phase = 2; rk = 0; wait_cyc = cyc;
                end else if (wcnt != 0) begin
                    wcnt--;
                end
            end else if (dev_phase == 2) begin
                rk++;
                if (dev_wr && wr_ready) begin
                    dev_mem[(dev_addr + beat) & MASK] = data;
                    beat++;
                end
                if (!dev_wr && !oe && rk >= RDL) begin
                    dev_q = dev_rd((dev_addr + rk - RDL) & MASK);
                    dev_drive = 1'b1;
                end
            end
        end
    end

    // Host write stream: present the next unconsumed word after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            wr_data = wbuf[wr_idx % 256];
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin ok = 1; break; end
            step();
        end
        if (!ok) check(tag, 0, 1);
        idle_cyc = cyc;
    endtask

    task automatic cfg_seq();
        reset = 1'b1;
        step();
        check("cfg_ce_cre", {ce, cre}, 2'b01);
        check("cfg_addr", addr, BCR);
        check("cfg_busy", busy, 1);
        step();
        check("cfg_wait_ce_cre", {ce, cre}, 2'b00);
        wait_idle("cfg_idle_timeout");
        check("busy_fall", idle_cyc - wait_cyc, 2);
    endtask

    task automatic burst(input bit w, input int a, input int l8,
                         input logic [15:0] seed, input bit inject);
        int n, d0, r0, w0, mism;
        bit ok;
        n = (l8 == 0) ? 256 : l8;
        wait_idle("pre_burst_idle");
        d0 = n_done; r0 = n_rd; w0 = n_wr;
        if (w) begin
            for (int i = 0; i < n; i++) begin
                wbuf[i] = (seed != 16'h0) ? seed + 16'(i) : 16'($urandom);
                ref_mem[(a + i) & MASK] = wbuf[i];
            end
            wr_idx = 0; wr_data = wbuf[0]; first_wr_pend = 1;
        end else begin
            for (int i = 0; i < n; i++) rd_q.push_back(ref_rd((a + i) & MASK));
            first_rd_pend = 1;
        end
        req = 1'b1; req_we = w; req_addr = a[22:0]; req_len = l8[7:0];
        step();
        req = 1'b0; req_addr = 23'($urandom); req_len = 8'($urandom);
        ok = 0;
        for (int k = 0; k < 700; k++) begin
            if (n_done != d0) begin ok = 1; break; end
            if (inject && (k == 2 || k == 4)) begin
                check("inject_while_busy", busy, 1);
                req = 1'b1; req_we = ~w;
            end else begin
                req = 1'b0;
            end
            step();
        end
        req = 1'b0;
        check("burst_done_seen", ok, 1);
        repeat (12) step();
        check("done_count", n_done - d0, 1);
        if (w) begin
            check("wr_beats", n_wr - w0, n);
            check("wr_consecutive", last_wr_cyc - first_wr_cyc, n - 1);
            check("wr_done_after_last", done_cyc - last_wr_cyc, 1);
            mism = 0;
            for (int i = 0; i < n; i++)
                if (!dev_mem.exists((a + i) & MASK) || dev_mem[(a + i) & MASK] !== wbuf[i]) mism++;
            check("wr_mem_words", mism, 0);
        end else begin
            check("rd_beats", n_rd - r0, n);
            check("rd_latency", first_rd_cyc - wait_cyc, RDL + 1);
            check("rd_left", rd_q.size(), 0);
        end
    endtask

    initial begin
        int d0, r0, e0;
        bit ok;
        for (int i = 0; i < 256; i++) wbuf[i] = '0;

        // Reset values
        reset = 1'b0;
        repeat (3) step();
        check("rst_ctl", {ce, we, oe, adv, cre, lb, ub}, 7'b1111011);
        check("rst_flags", {busy, wr_ready, rd_valid, done, err}, 5'b10000);
        check("rst_addr", addr, 0);
        check("rst_rd_data", rd_data, 0);

        cfg_seq();

        // Directed write then read at 0x100
        burst(1'b1, 'h100, 4, 16'hA000, 1'b0);
        for (int i = 0; i < 4; i++)
            check("wr_readback", dev_mem['h100 + i], 16'hA000 + 16'(i));
        burst(1'b0, 'h100, 4, 16'h0, 1'b0);

        // len=0 means 256 beats
        burst(1'b1, 'h1000, 0, 16'h0, 1'b0);
        burst(1'b0, 'h1000, 0, 16'h0, 1'b0);

        // Random bursts, some wrapping past the top of the address space
        for (int t = 0; t < 10; t++) begin
            int a;
            a = (t % 4 == 3) ? ('h7FFFF0 + int'($urandom_range(0, 15)))
                             : int'($urandom_range(0, 'h3FF));
            burst(1'($urandom_range(0, 1)), a, int'($urandom_range(1, 24)), 16'h0, 1'b0);
        end

        // req pulses while busy must be ignored
        burst(1'b1, 'h300, 8, 16'h0, 1'b1);
        burst(1'b0, 'h300, 8, 16'h0, 1'b1);

        // Reset dropped in the middle of a read burst
        wait_idle("pre_rst_idle");
        d0 = n_done; r0 = n_rd;
        for (int i = 0; i < 16; i++) rd_q.push_back(ref_rd('h200 + i));
        req = 1'b1; req_we = 1'b0; req_addr = 23'h200; req_len = 8'd16;
        step();
        req = 1'b0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (n_rd > r0) begin ok = 1; break; end
            step();
        end
        check("mid_rst_read_started", ok, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ctl", {ce, we, oe, adv, cre, lb, ub}, 7'b1111011);
        check("mid_rst_flags", {busy, wr_ready, rd_valid, done, err}, 5'b10000);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_rd_data", rd_data, 0);
        rd_q.delete();
        step();
        step();
        cfg_seq();
        check("mid_rst_no_done", n_done - d0, 0);
        burst(1'b0, 'h100, 4, 16'h0, 1'b0);

`ifdef CELLRAM_CTRL_TIMEOUT_EN
        wait_idle("pre_to_idle");
        dev_stall = 1;
        d0 = n_done; e0 = n_err; r0 = n_rd;
        req = 1'b1; req_we = 1'b0; req_addr = 23'h40; req_len = 8'd4;
        step();
        req = 1'b0;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (n_err != e0) begin ok = 1; break; end
            step();
        end
        check("to_err_seen", ok, 1);
        check("to_latency", err_cyc - adv_cyc, TMO + 1);
        check("to_ce_high", ce_at_err, 1);
        repeat (4) step();
        check("to_no_done", n_done - d0, 0);
        check("to_no_beats", n_rd - r0, 0);
        check("to_err_once", n_err - e0, 1);
        dev_stall = 0;
        burst(1'b1, 'h40, 3, 16'h0, 1'b0);
`else
        check("err_tied_low", n_err, 0);
`endif

        check("lb_ub_follow_ce", lbub_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cellram_ctrl.md
Name: cellram_ctrl

Overview:
Burst controller that sits directly upstream of the CellRAM device model and turns host-side word-burst requests into CellRAM control sequences (ce/we/oe/cre/adv/lb/ub, address, bidirectional data). After reset it writes the bus configuration register (BCR) once, then serves one read or write burst at a time. The host side uses a req/busy/done handshake, a pull-style write stream and a push-style read stream.

Parameters:
BCR_VALUE, 23'h009D1F, word presented on addr during the configuration cycle (cre high).
RD_LAT, 2, cycles from first sampled mem_wait=1 in a read to first valid word on data.
TIMEOUT, 16, max cycles to wait for mem_wait=1 (used only with the optional feature).

Ports:
clk  in  1  system clock; all device outputs launched on rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  1  start burst; sampled only when busy=0.
req_we  in  1  1=write burst, 0=read burst; sampled with req.
req_addr  in  23  start word address; sampled with req.
req_len  in  8  burst length in words; 0 means 256.
wr_data  in  16  write word; consumed on cycles where wr_ready=1.
wr_ready  out  1  pulse: wr_data consumed this cycle.
rd_data  out  16  read word, valid when rd_valid=1.
rd_valid  out  1  pulse per read word.
busy  out  1  high from reset until config done, and from req accept until done.
done  out  1  one-cycle pulse at burst end.
err  out  1  one-cycle timeout pulse (always 0 without the optional feature).
ce, we, oe, cre, adv, lb, ub  out  1 each  CellRAM controls; all active low except cre.
addr  out  23  device address / BCR value.
data  inout  16  device data; driven only during write beats, otherwise high-Z.
mem_wait  in  1  device wait; treat Z/X as 0.

Behaviour:
- Reset (async, reset=0): state CFG; ce=we=oe=adv=1, lb=ub=1, cre=0, addr=0, data high-Z, busy=1, wr_ready=rd_valid=done=err=0, rd_data=0.
- Byte enables: lb=ub=0 whenever ce=0. Width rule: an internal 9-bit beat counter loaded with req_len, with 0 → 256.
- States: CFG, CFG_WAIT, IDLE, ADDR, WAIT, WR_BURST, RD_BURST, RECOVER.
- CFG: first cycle after reset release, drive ce=0, cre=1, addr=BCR_VALUE; next cycle go to CFG_WAIT.
- CFG_WAIT: hold ce=0, drop cre; on mem_wait=1 go to RECOVER (then IDLE, busy=0).
- IDLE: busy=0. On req=1, latch req_we/req_addr/req_len, set busy=1, go to ADDR. A req raised while busy=1 is ignored; it is not queued.
- ADDR (1 cycle): ce=0, adv=0, addr=latched address, we=~req_we, oe=1. Then go to WAIT with adv=1 and we held.
- WAIT: hold ce=0 until mem_wait=1 is sampled. Write: go to WR_BURST. Read: assert oe=0 and go to RD_BURST.
- WR_BURST: every cycle drive data=wr_data, wr_ready=1, decrement the beat count. The wr_ready=1 cycle on which the count reaches 1 is the last beat; the next state is RECOVER. The host must hold valid wr_data during the burst; there is no back-pressure.
- RD_BURST: skip RD_LAT cycles, then sample data into rd_data with rd_valid=1 for exactly len consecutive cycles, then go to RECOVER.
- RECOVER (1 cycle): ce=1, we=oe=1, data high-Z, done=1 (except for the config pass). Then go to IDLE. Minimum 1 cycle of ce=1 between bursts.
- Latency: req accept → first wr_ready = 2 + device wait (3) = 5 cycles nominal. First rd_valid = that + RD_LAT.
- Address wrap: the device increments internally; the controller does not check the 8M boundary.
- Reset asserted mid-burst: immediate return to reset values, no done pulse. After release, BCR configuration is repeated.

Optional Feature:
CELLRAM_CTRL_TIMEOUT_EN
- With the macro: a counter runs in CFG_WAIT and WAIT. If TIMEOUT cycles pass with no mem_wait=1, pulse err=1 and go to RECOVER. No done pulse and no data beats occur.
- Without the macro: wait forever; err is tied to 0.

Test Plan:
- Reset release → ce=0, cre=1, addr=23'h009D1F for 1 cycle; busy falls 1 cycle after the RECOVER cycle that follows mem_wait=1.
- Write req_addr=0x000100, len=4, data 0xA000..0xA003 → 4 consecutive wr_ready pulses, then done; readback shows the model holds those words at 0x100..0x103.
- Read req_addr=0x000100, len=4 → 4 consecutive rd_valid with 0xA000..0xA003; first beat comes RD_LAT cycles after mem_wait rises; then done.
- len=0 write → exactly 256 wr_ready pulses.
- req pulsed while busy=1 → ignored (single done); reset dropped during RD_BURST → all outputs return to reset values immediately, and the config sequence reruns.
- With CELLRAM_CTRL_TIMEOUT_EN, mem_wait held 0 → err pulse exactly 16 cycles after entering WAIT, no done, ce=1 next cycle.
